// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams data-memory words out while holding the CPU; optional trailing checksum with MEM_DUMP_CHECKSUM_EN
module mem_dump_reader #(
    parameter int ADDR_STEP     = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        hold,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);
`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HOLD, READ, SEND, CSUM, DONE} state_t;
    localparam state_t FINISH = CSUM;
    logic [31:0] checksum;
`else
    typedef enum logic [2:0] {IDLE, HOLD, READ, SEND, DONE} state_t;
    localparam state_t FINISH = DONE;
`endif
    state_t state, nextState;
    logic [31:0] baseAddr;
    logic [15:0] count;
    logic [15:0] wordIndex;
    logic [3:0]  settleCnt;
    logic        lastSettle;
    logic        lastWord;
    assign lastSettle = settleCnt == 4'(SETTLE_CYCLES - 1);
    assign lastWord   = ({1'b0, wordIndex} + 17'd1) >= {1'b0, count};
    // State register; reset abandons any transfer immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end
    // Next-state and Moore outputs
    always_comb begin
        nextState = state;
        hold      = state != IDLE;
        busy      = state != IDLE;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: nextState = start ? HOLD : IDLE;
            HOLD: nextState = !lastSettle ? HOLD : (count != 16'd0 ? READ : FINISH);
            READ: nextState = SEND;
            SEND: begin
                out_valid = 1'b1;
                nextState = !out_ready ? SEND : (lastWord ? FINISH : READ);
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                nextState = out_ready ? DONE : CSUM;
            end
`endif
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end
    // Request capture, address stepping, read-data latch and checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baseAddr  <= '0;
            count     <= '0;
            wordIndex <= '0;
            settleCnt <= '0;
            mem_addr  <= '0;
            out_data  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            if (state == IDLE && start) begin
                baseAddr  <= base_addr;
                count     <= word_count;
                wordIndex <= '0;
                settleCnt <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                checksum  <= '0;
`endif
            end
            if (state == HOLD) settleCnt <= settleCnt + 4'd1;
            if (state == HOLD && nextState == READ) mem_addr <= baseAddr;
            if (state == READ) out_data <= mem_rdata;
            if (state == SEND && out_ready) begin
                wordIndex <= wordIndex + 16'd1;
                if (nextState == READ) mem_addr <= mem_addr + 32'(ADDR_STEP);
`ifdef MEM_DUMP_CHECKSUM_EN
                checksum <= checksum + out_data;
`endif
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            if (state != CSUM && nextState == CSUM) out_data <= state == SEND ? checksum + out_data : checksum;
`endif
        end
    end
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: directed and randomized dumps checked against a queue-based reference model
module tb_mem_dump_reader;
    localparam int STEP   = 4;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        reset, start, out_ready, hold, out_valid, busy, done;
    logic [31:0] base_addr, mem_rdata, mem_addr, out_data;
    logic [15:0] word_count;
    logic [31:0] seed = '0;
    int          compared = 0;
    int          mismatched = 0;

    mem_dump_reader #(.ADDR_STEP(STEP), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .hold(hold), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memAt(input logic [31:0] a, input logic [31:0] s);
        return (((a >> 2) + 32'd1) * 32'h11) ^ s;
    endfunction

    assign mem_rdata = memAt(mem_addr, seed);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic runDump(input logic [31:0] base, input logic [15:0] cnt, input int stallWord,
                           input int stallLen, input bit randReady, input bit poke);
        logic [31:0] expQ[$];
        logic [31:0] gotQ[$];
        logic [31:0] addrQ[$];
        logic [31:0] sum = '0;
        logic [31:0] prevData = '0;
        logic [31:0] prevAddr = '0;
        bit prevStall = 1'b0;
        bit doneSeen = 1'b0;
        int edges = 1;
        int firstValid = -1;
        int holdCycles = 0;
        int lastHs = -1;
        int doneCyc = -1;
        int stalled = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            expQ.push_back(memAt(base + 32'(i * STEP), seed));
            sum += expQ[i];
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        expQ.push_back(sum);
`endif
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = cnt; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = 16'($urandom);
        for (int cyc = 0; cyc < 400 && !doneSeen; cyc++) begin
            @(negedge clk);
            if (hold) holdCycles++;
            if (out_valid && firstValid < 0) firstValid = edges;
            if (prevStall) begin
                check("stall_data", out_data, prevData);
                check("stall_addr", mem_addr, prevAddr);
            end
            if (out_valid && out_ready) begin
                if (gotQ.size() > 0 && gotQ.size() < int'(cnt) && stallLen == 0 && !randReady)
                    check("throughput", 32'(cyc - lastHs), 32'd2);
                gotQ.push_back(out_data);
                addrQ.push_back(mem_addr);
                lastHs = cyc;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevAddr  = mem_addr;
            if (done) begin
                doneSeen = 1'b1;
                doneCyc  = cyc;
            end else begin
                @(posedge clk); edges++; #1;
                start = poke && cyc == 0;
                if (start) begin
                    base_addr  = ~base;
                    word_count = cnt + 16'd3;
                end
                if (out_valid && gotQ.size() == stallWord && stalled < stallLen) begin
                    out_ready = 1'b0;
                    stalled++;
                end else out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(doneSeen), 32'd1);
        check("word_total", 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) check("data", gotQ[i], expQ[i]);
        for (int i = 0; i < int'(cnt) && i < addrQ.size(); i++) check("addr", addrQ[i], base + 32'(i * STEP));
        if (cnt != 16'd0) check("latency", 32'(firstValid), 32'(SETTLE + 2));
        if (lastHs >= 0) check("done_after_hs", 32'(doneCyc - lastHs), 32'd1);
`ifndef MEM_DUMP_CHECKSUM_EN
        if (cnt == 16'd0) check("hold_len", 32'(holdCycles), 32'(SETTLE + 1));
`endif
        @(negedge clk);
        check("idle_hold", 32'(hold), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        int nv;
        bit sawDone;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; word_count = '0;
        #2;
        check("rst_hold", 32'(hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_data", out_data, 32'd0);
        @(negedge clk); reset = 1'b0;
        runDump(32'h0, 16'd3, -1, 0, 1'b0, 1'b0);
        runDump(32'h0, 16'd3, 1, 5, 1'b0, 1'b0);
        runDump(32'h0, 16'd0, -1, 0, 1'b0, 1'b0);
        runDump(32'hFFFF_FFFC, 16'd2, -1, 0, 1'b0, 1'b0);
        runDump(32'h40, 16'd4, -1, 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h200; word_count = 16'd4; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0;
        for (int c = 0; c < 50 && nv < 2; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("reach_send2", 32'(nv), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_hold", 32'(hold), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        sawDone = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        check("arst_no_done", 32'(sawDone), 32'd0);
        reset = 1'b0;
        runDump(32'h300, 16'd3, -1, 0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            seed = $urandom;
            runDump($urandom, 16'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), 1'b1, 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 4, byte increment between consecutive word addresses.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1 (legal 1..15), cycles `hold` is high before the first memory read.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, dump request, sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, 32, byte address of the first word, captured on start.
REQ-007 SHALL have port word_count, input, 16, number of words to dump, captured on start.
REQ-008 SHALL have port mem_rdata, input, 32, data-memory read data, combinational from mem_addr.
REQ-009 SHALL have port mem_addr, output, 32, data-memory address driven to the memory during the dump.
REQ-010 SHALL have port hold, output, 1, CPU hold request; the top ORs it into the processor reset so the read-side address mux selects mem_addr.
REQ-011 SHALL have port out_data, output, 32, dumped word.
REQ-012 SHALL have port out_valid, output, 1, out_data valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at dump completion.

Function
REQ-016 SHALL implement states IDLE, HOLD, READ, SEND, CSUM and DONE.
REQ-017 IDLE -> HOLD on start=1; SHALL capture base_addr, word_count, clear word index and settle counter.
REQ-018 SHALL keep hold=1 in HOLD, READ, SEND, CSUM and DONE; hold=0 in IDLE.
REQ-019 SHALL stay in HOLD for exactly SETTLE_CYCLES cycles, then go to READ if remaining count > 0, else to CSUM (macro defined) or DONE.
REQ-020 In READ (one cycle), mem_addr SHALL equal base + index*ADDR_STEP modulo 2^32, and mem_rdata SHALL be registered into out_data at the cycle's end; next state SEND.
REQ-021 mem_addr SHALL hold its last value outside READ; reset value 0.
REQ-022 In SEND, out_valid=1; out_data SHALL stay stable until the cycle where out_valid and out_ready are both 1.
REQ-023 On a SEND handshake, SHALL increment index and go to READ if index+1 < count, else to CSUM or DONE.
REQ-024 First out_valid SHALL occur SETTLE_CYCLES+2 cycles after the start-sampling edge; steady-state throughput SHALL be one word per 2 cycles when out_ready=1.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 word_count=0 SHALL perform no memory reads and produce no data words, but SHALL still emit the checksum (if enabled) and the done pulse.
REQ-028 Address arithmetic SHALL wrap at 2^32 without error indication.

Reset
REQ-029 On reset=1, SHALL go to IDLE immediately, regardless of clk.
REQ-030 On reset=1, out_valid, hold, busy and done SHALL be 0, and mem_addr, out_data, index and checksum SHALL be 0.
REQ-031 Reset mid-dump SHALL abandon the transfer with no done pulse; a new start after reset release SHALL begin from the newly captured base_addr.

Configuration
REQ-032 Macro MEM_DUMP_CHECKSUM_EN, when defined, SHALL enable CSUM: the block accumulates the 32-bit modulo sum of every word accepted in SEND.
REQ-033 With the macro defined, CSUM SHALL present the sum on out_data with out_valid=1, using the same handshake rules as SEND, then go to DONE.
REQ-034 With the macro defined, the checksum SHALL clear on start.
REQ-035 Without the macro, CSUM and the accumulator SHALL not exist, and the last SEND or HOLD transitions directly to DONE.

Verification
REQ-036 Memory words 0x11,0x22,0x33 at 0x0,0x4,0x8; base=0, count=3, out_ready=1 -> out_data 0x11,0x22,0x33; first out_valid 3 cycles after start edge; done 1 cycle after last handshake (checksum 0x66 first when enabled).
REQ-037 Same dump with out_ready low for 5 cycles on word 2 -> out_data=0x22 and mem_addr held stable throughout; no word lost or duplicated.
REQ-038 count=0 -> hold high for SETTLE_CYCLES+1 cycles, no data words, done pulse (checksum word 0x0 when enabled).
REQ-039 base=0xFFFFFFFC, count=2 -> mem_addr sequence 0xFFFFFFFC then 0x00000000.
REQ-040 reset asserted asynchronously during the second SEND -> out_valid, hold and busy go 0 before the next clk edge; no done pulse; restart dumps correctly.
REQ-041 start pulsed while busy -> ignored; word count and addresses unchanged.
